// File: rtl/router_pair_scheduler_if.sv
// rtl/router_pair_scheduler_if.sv - scheduler <-> input/weight router handshake bundle
interface router_pair_scheduler_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  o_ir_en;
    logic                  o_wr_en;
    logic                  o_ir_reg_clear;
    logic                  o_wr_reg_clear;
    logic [ADDR_WIDTH-1:0] o_ir_start_addr;
    logic [ADDR_WIDTH-1:0] o_ir_addr_end;
    logic [ADDR_WIDTH-1:0] o_wr_start_addr;
    logic [ADDR_WIDTH-1:0] o_wr_addr_end;
    logic                  i_ir_ready;
    logic                  i_wr_ready;
    logic                  i_ir_context_done;
    logic                  i_wr_context_done;
    logic                  o_ir_pop_en;
    logic                  o_wr_pop_en;

    modport master (
        output o_ir_en, o_wr_en, o_ir_reg_clear, o_wr_reg_clear,
        output o_ir_start_addr, o_ir_addr_end, o_wr_start_addr, o_wr_addr_end,
        output o_ir_pop_en, o_wr_pop_en,
        input  i_ir_ready, i_wr_ready, i_ir_context_done, i_wr_context_done
    );

    modport slave (
        input  o_ir_en, o_wr_en, o_ir_reg_clear, o_wr_reg_clear,
        input  o_ir_start_addr, o_ir_addr_end, o_wr_start_addr, o_wr_addr_end,
        input  o_ir_pop_en, o_wr_pop_en,
        output i_ir_ready, i_wr_ready, i_ir_context_done, i_wr_context_done
    );
endinterface

// File: rtl/router_pair_scheduler.sv
// rtl/router_pair_scheduler.sv - sequences an input/weight router pair through a layer of contexts
module router_pair_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int CTX_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [CTX_WIDTH-1:0]  i_ctx_count,
    input  logic [ADDR_WIDTH-1:0] i_ir_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_ir_ctx_stride,
    input  logic [ADDR_WIDTH-1:0] i_ir_ctx_len,
    input  logic [ADDR_WIDTH-1:0] i_wr_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_wr_ctx_stride,
    input  logic [ADDR_WIDTH-1:0] i_wr_ctx_len,
    input  logic                  i_sa_stall,
    router_pair_scheduler_if.master rif,
    output logic [CTX_WIDTH-1:0]  o_ctx_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sync_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_WAIT_RDY, S_STREAM, S_NEXT, S_DONE
    } state_t;

    state_t                state_q;
    logic [CTX_WIDTH-1:0]  ctx_cnt_q, ctx_idx_q;
    logic [ADDR_WIDTH-1:0] ir_stride_q, ir_len_q, ir_start_q, ir_end_q;
    logic [ADDR_WIDTH-1:0] wr_stride_q, wr_len_q, wr_start_q, wr_end_q;
    logic                  ir_fin_q, wr_fin_q;
    logic                  clear_q, en_q, done_q, sync_err_q;

    logic                  ir_fin_d, wr_fin_d, in_stream;
    logic [CTX_WIDTH-1:0]  ctx_idx_d;

    // A router counts as finished in the very cycle its done arrives, so its pops drop immediately.
    assign ir_fin_d  = ir_fin_q | rif.i_ir_context_done;
    assign wr_fin_d  = wr_fin_q | rif.i_wr_context_done;
    assign in_stream = (state_q == S_STREAM);
    assign ctx_idx_d = ctx_idx_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            ctx_cnt_q   <= '0;
            ctx_idx_q   <= '0;
            ir_stride_q <= '0;
            ir_len_q    <= '0;
            ir_start_q  <= '0;
            ir_end_q    <= '0;
            wr_stride_q <= '0;
            wr_len_q    <= '0;
            wr_start_q  <= '0;
            wr_end_q    <= '0;
            ir_fin_q    <= 1'b0;
            wr_fin_q    <= 1'b0;
            clear_q     <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            if (i_abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (i_start) begin
                        ctx_cnt_q   <= i_ctx_count;
                        ir_stride_q <= i_ir_ctx_stride;
                        ir_len_q    <= i_ir_ctx_len;
                        wr_stride_q <= i_wr_ctx_stride;
                        wr_len_q    <= i_wr_ctx_len;
                        ir_start_q  <= i_ir_base_addr;
                        wr_start_q  <= i_wr_base_addr;
                        ctx_idx_q   <= '0;
                        sync_err_q  <= 1'b0;
                        if (i_ctx_count == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_CLEAR;
                            clear_q <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        ir_fin_q <= 1'b0;
                        wr_fin_q <= 1'b0;
                        ir_end_q <= ir_start_q + ir_len_q - ADDR_WIDTH'(1);
                        wr_end_q <= wr_start_q + wr_len_q - ADDR_WIDTH'(1);
                        en_q     <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                    S_LOAD: state_q <= S_WAIT_RDY;
                    S_WAIT_RDY: if (rif.i_ir_ready && rif.i_wr_ready) state_q <= S_STREAM;
                    S_STREAM: begin
                        ir_fin_q <= ir_fin_d;
                        wr_fin_q <= wr_fin_d;
                        if (ir_fin_d != wr_fin_d) sync_err_q <= 1'b1;
                        if (ir_fin_d && wr_fin_d) state_q <= S_NEXT;
                    end
                    S_NEXT: begin
                        ir_start_q <= ir_start_q + ir_stride_q;
                        wr_start_q <= wr_start_q + wr_stride_q;
                        if (ctx_idx_d == ctx_cnt_q) begin
                            state_q <= S_DONE;
                        end else begin
                            ctx_idx_q <= ctx_idx_d;
                            clear_q   <= 1'b1;
                            state_q   <= S_CLEAR;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rif.o_ir_reg_clear  = clear_q;
    assign rif.o_wr_reg_clear  = clear_q;
    assign rif.o_ir_en         = en_q;
    assign rif.o_wr_en         = en_q;
    assign rif.o_ir_start_addr = ir_start_q;
    assign rif.o_ir_addr_end   = ir_end_q;
    assign rif.o_wr_start_addr = wr_start_q;
    assign rif.o_wr_addr_end   = wr_end_q;
    assign rif.o_ir_pop_en     = in_stream && !i_sa_stall && !ir_fin_d;
    assign rif.o_wr_pop_en     = in_stream && !i_sa_stall && !wr_fin_d;
    assign o_ctx_idx           = ctx_idx_q;
    assign o_busy              = (state_q != S_IDLE);
    assign o_done              = done_q;
    assign o_sync_err          = sync_err_q;
endmodule
